// File: rtl/mc_control_fsm.sv
// Multi-cycle IF/ID/EX/MEM/WB control unit for the 16-bit TSC CPU.
// It drives every datapath enable and mux select, handshakes with memory and has a memory timeout.
module mc_control_fsm #(
    parameter int WORD_SIZE   = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WORD_SIZE/4-1:0] opcode,
    input  logic [5:0]             func,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   pc_write_cond,
    output logic [1:0]             pc_source,
    output logic                   i_or_d,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic                   reg_write,
    output logic [1:0]             reg_dst,
    output logic [1:0]             wb_src,
    output logic                   alu_src_b,
    output logic                   wwd_en,
    output logic                   inst_done,
    output logic                   halted,
    output logic                   mem_error
);
    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT, S_ERR} state_t;

    localparam logic [3:0] OP_LWD = 4'd7;
    localparam logic [3:0] OP_SWD = 4'd8;
    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_JAL = 4'd10;
    localparam logic [3:0] OP_R   = 4'd15;
    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       waiting;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = '0;
        waiting       = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'd0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 2'd0;
        wb_src        = 2'd0;
        alu_src_b     = 1'b0;
        wwd_en        = 1'b0;
        inst_done     = 1'b0;
        halted        = 1'b0;
        mem_error     = 1'b0;
        // Everything stays at its zero default while reset is high.
        if (!reset) begin
            unique case (state_q)
                S_IF: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_ID;
                    end else begin
                        waiting = 1'b1;
                    end
                end
                S_ID: begin
                    state_d = S_IF;
                    if (opcode == OP_JMP || opcode == OP_JAL) begin
                        pc_write  = 1'b1;
                        pc_source = 2'd2;
                        inst_done = 1'b1;
                        if (opcode == OP_JAL) begin
                            reg_write = 1'b1;
                            reg_dst   = 2'd2;
                            wb_src    = 2'd2;
                        end
                    end else if (opcode == OP_R) begin
                        inst_done = 1'b1;
                        if (func == FN_JPR || func == FN_JRL) begin
                            pc_write  = 1'b1;
                            pc_source = 2'd3;
                            if (func == FN_JRL) begin
                                reg_write = 1'b1;
                                reg_dst   = 2'd2;
                                wb_src    = 2'd2;
                            end
                        end else if (func == FN_WWD) begin
                            wwd_en = 1'b1;
                        end else if (func == FN_HLT) begin
                            state_d = S_HALT;
                        end else if (func < 6'd8) begin
                            inst_done = 1'b0;
                            state_d   = S_EX;
                        end
                    end else if (opcode <= OP_SWD) begin
                        state_d = S_EX;
                    end else begin
                        inst_done = 1'b1;  // opcodes 11-14 retire as NOP
                    end
                end
                S_EX: begin
                    state_d = S_WB;
                    if (opcode <= 4'd3) begin
                        pc_write_cond = 1'b1;
                        pc_source     = 2'd1;
                        inst_done     = 1'b1;
                        state_d       = S_IF;
                    end else if (opcode == OP_LWD || opcode == OP_SWD) begin
                        alu_src_b = 1'b1;
                        state_d   = S_MEM;
                    end else if (opcode != OP_R) begin
                        alu_src_b = 1'b1;
                    end
                end
                S_MEM: begin
                    i_or_d    = 1'b1;
                    mem_read  = (opcode == OP_LWD);
                    mem_write = (opcode == OP_SWD);
                    if (mem_ready) begin
                        if (opcode == OP_LWD) begin
                            state_d = S_WB;
                        end else begin
                            inst_done = 1'b1;
                            state_d   = S_IF;
                        end
                    end else begin
                        waiting = 1'b1;
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    inst_done = 1'b1;
                    state_d   = S_IF;
                    if (opcode == OP_LWD) wb_src = 2'd1;
                    else if (opcode == OP_R) reg_dst = 2'd1;
                end
                S_HALT: halted = 1'b1;
                S_ERR:  mem_error = 1'b1;
                default: state_d = S_IF;
            endcase
            if (waiting) begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == TO_LAST) state_d = S_ERR;
            end
        end
    end
endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-cycle output vectors checked against hand-derived values.
module tb_mc_control_fsm;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = '0;
    logic [5:0] func = '0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic       alu_src_b, wwd_en, inst_done, halted, mem_error;
    logic [1:0] pc_source, reg_dst, wb_src;

    int n_chk = 0;
    int n_pass = 0;
    int n_done;

    mc_control_fsm #(.WORD_SIZE(16), .MEM_TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .func(func), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .wb_src(wb_src), .alu_src_b(alu_src_b),
        .wwd_en(wwd_en), .inst_done(inst_done), .halted(halted), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    localparam logic [17:0] PCW = 18'h20000, PCWC = 18'h10000, IORD = 18'h02000;
    localparam logic [17:0] MRD = 18'h01000, MWR = 18'h00800, IRW = 18'h00400, RGW = 18'h00200;
    localparam logic [17:0] ASB = 18'h00010, WWD = 18'h00008, DONE = 18'h00004;
    localparam logic [17:0] HLT = 18'h00002, MERR = 18'h00001;
    localparam logic [17:0] FETCH = MRD | IRW | PCW;

    function automatic logic [17:0] pcs(input logic [1:0] v);  return 18'(v) << 14; endfunction
    function automatic logic [17:0] rdst(input logic [1:0] v); return 18'(v) << 7;  endfunction
    function automatic logic [17:0] wbs(input logic [1:0] v);  return 18'(v) << 5;  endfunction

    wire [17:0] obs = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                       reg_write, reg_dst, wb_src, alu_src_b, wwd_en, inst_done, halted, mem_error};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Apply inputs for one cycle, check outputs mid-cycle, then advance past the next edge.
    task automatic cyc(input logic [3:0] op, input logic [5:0] fn, input logic rdy,
                       input string tag, input logic [17:0] e);
        opcode = op; func = fn; mem_ready = rdy;
        @(negedge clk);
        chk(tag, 32'(obs), 32'(e));
        if (inst_done) n_done++;
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset held for two edges with memory ready: outputs must stay 0.
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_outs", 32'(obs), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        n_done = 0;

        cyc(4'd15, 6'd0, 1'b1, "rst_if", FETCH);
        cyc(4'd15, 6'd0, 1'b1, "add_id", 18'h0);
        cyc(4'd15, 6'd0, 1'b1, "add_ex", 18'h0);
        cyc(4'd15, 6'd0, 1'b1, "add_wb", RGW | rdst(2'd1) | DONE);

        // Ten back-to-back ADDs in 40 cycles.
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(4'd15, 6'd0, 1'b1, "add10_if", FETCH);
            cyc(4'd15, 6'd0, 1'b1, "add10_id", 18'h0);
            cyc(4'd15, 6'd0, 1'b1, "add10_ex", 18'h0);
            cyc(4'd15, 6'd0, 1'b1, "add10_wb", RGW | rdst(2'd1) | DONE);
        end
        chk("add10_count", 32'(n_done), 32'd10);

        // LWD with three wait cycles in both IF and MEM: writeback on cycle 11.
        for (int i = 0; i < 3; i++) cyc(4'd7, 6'd0, 1'b0, "lwd_if_wait", MRD);
        cyc(4'd7, 6'd0, 1'b1, "lwd_if", FETCH);
        cyc(4'd7, 6'd0, 1'b1, "lwd_id", 18'h0);
        cyc(4'd7, 6'd0, 1'b1, "lwd_ex", ASB);
        for (int i = 0; i < 3; i++) cyc(4'd7, 6'd0, 1'b0, "lwd_mem_wait", IORD | MRD);
        cyc(4'd7, 6'd0, 1'b1, "lwd_mem", IORD | MRD);
        cyc(4'd7, 6'd0, 1'b1, "lwd_wb", RGW | wbs(2'd1) | DONE);

        // mem_ready outside IF/MEM must not matter; JAL completes in ID.
        cyc(4'd10, 6'd0, 1'b1, "jal_if", FETCH);
        cyc(4'd10, 6'd0, 1'b0, "jal_id", PCW | pcs(2'd2) | RGW | rdst(2'd2) | wbs(2'd2) | DONE);
        cyc(4'd10, 6'd0, 1'b0, "jal_next_if", MRD);
        cyc(4'd0, 6'd0, 1'b1, "bne_if", FETCH);
        cyc(4'd0, 6'd0, 1'b1, "bne_id", 18'h0);
        cyc(4'd0, 6'd0, 1'b1, "bne_ex", PCWC | pcs(2'd1) | DONE);
        cyc(4'd5, 6'd0, 1'b1, "ori_if", FETCH);
        cyc(4'd5, 6'd0, 1'b1, "ori_id", 18'h0);
        cyc(4'd5, 6'd0, 1'b1, "ori_ex", ASB);
        cyc(4'd5, 6'd0, 1'b1, "ori_wb", RGW | DONE);
        cyc(4'd15, 6'd26, 1'b1, "jrl_if", FETCH);
        cyc(4'd15, 6'd26, 1'b1, "jrl_id", PCW | pcs(2'd3) | RGW | rdst(2'd2) | wbs(2'd2) | DONE);
        cyc(4'd15, 6'd28, 1'b1, "wwd_if", FETCH);
        cyc(4'd15, 6'd28, 1'b1, "wwd_id", WWD | DONE);
        cyc(4'd12, 6'd0, 1'b1, "nop_if", FETCH);
        cyc(4'd12, 6'd0, 1'b1, "nop_id", DONE);
        cyc(4'd15, 6'd40, 1'b1, "badfn_if", FETCH);
        cyc(4'd15, 6'd40, 1'b1, "badfn_id", DONE);

        // HLT, then 20 ready cycles in HALT with no activity.
        cyc(4'd15, 6'd29, 1'b1, "hlt_if", FETCH);
        cyc(4'd15, 6'd29, 1'b1, "hlt_id", DONE);
        for (int i = 0; i < 20; i++) cyc(4'd15, 6'd29, 1'b1, "halt_hold", HLT);
        reset = 1'b1;
        cyc(4'd15, 6'd29, 1'b1, "halt_reset", 18'h0);
        reset = 1'b0;
        cyc(4'd8, 6'd0, 1'b1, "post_halt_if", FETCH);

        // SWD interrupted by reset while MEM has mem_write high.
        cyc(4'd8, 6'd0, 1'b1, "swd_id", 18'h0);
        cyc(4'd8, 6'd0, 1'b1, "swd_ex", ASB);
        cyc(4'd8, 6'd0, 1'b0, "swd_mem_wait", IORD | MWR);
        reset = 1'b1;
        cyc(4'd8, 6'd0, 1'b0, "swd_mid_reset", 18'h0);
        reset = 1'b0;
        cyc(4'd8, 6'd0, 1'b0, "swd_after_reset_if", MRD);

        // SWD stalled in MEM: 255 wait cycles, then sticky mem_error.
        cyc(4'd8, 6'd0, 1'b1, "to_if", FETCH);
        cyc(4'd8, 6'd0, 1'b1, "to_id", 18'h0);
        cyc(4'd8, 6'd0, 1'b1, "to_ex", ASB);
        for (int i = 0; i < 255; i++) cyc(4'd8, 6'd0, 1'b0, "to_wait", IORD | MWR);
        cyc(4'd8, 6'd0, 1'b0, "to_err", MERR);
        cyc(4'd8, 6'd0, 1'b1, "to_err_sticky", MERR);
        reset = 1'b1;
        cyc(4'd8, 6'd0, 1'b1, "err_reset", 18'h0);
        reset = 1'b0;
        cyc(4'd8, 6'd0, 1'b1, "err_cleared_if", FETCH);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
